// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative unsigned multiply / divide unit for a pipeline back end.
//   One shift-add (multiply) or restoring-divide step per cycle, WIDTH
//   steps per operation; division by zero short-circuits straight to DONE.
//
// Ports
//   clk_i     in   1      clock, rising edge
//   rst_ni    in   1      asynchronous active-low reset
//   start_i   in   1      request new operation (looked at only in IDLE)
//   op_i      in   2      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a_i       in   WIDTH  operand A / dividend
//   b_i       in   WIDTH  operand B / divisor
//   flush_i   in   1      abort any operation in progress
//   busy_o    out  1      iterating (CALC)
//   done_o    out  1      one-cycle pulse, result_o valid
//   result_o  out  WIDTH  registered result, held until the next done_o
//   stall_o   out  1      combinational stall to the front end
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; operands captured on accept
// CALC  | one iteration per cycle, counter 0..WIDTH-1
// DONE  | single cycle, done_o high, result_o carries the new result

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             stall_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_b;
  // Multiply: {partial product high, multiplier shifting out of the low half}.
  // Divide:   low half holds dividend bits shifting out and quotient bits in.
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_result;

  logic                 w_accept;
  logic                 w_div0;
  logic                 w_last;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic                 w_borrow;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;
  logic [WIDTH-1:0]     w_calc_res;

  assign w_accept = start_i & ~flush_i;
  assign w_div0   = op_i[1] & (b_i == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Shift-add step: conditionally add B into the high half, then shift the
  // whole product right; the carry lands in the top bit.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_b : '0)};
  assign w_mul_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring divide step. The partial remainder is always < B, so the
  // shifted value fits WIDTH+1 bits and bit WIDTH of the trial is the borrow.
  assign w_shift   = {r_rem, r_prod[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_b};
  assign w_borrow  = w_trial[WIDTH];
  assign w_rem_nxt = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_prod[WIDTH-2:0], ~w_borrow};

  // Result taken from the next-state values so it is valid during DONE.
  always_comb begin
    w_calc_res = '0;
    case (r_op)
      OP_MUL:   w_calc_res = w_mul_nxt[WIDTH-1:0];
      OP_MULHU: w_calc_res = w_mul_nxt[2*WIDTH-1:WIDTH];
      OP_DIVU:  w_calc_res = w_quo_nxt;
      default:  w_calc_res = w_rem_nxt;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_div0 ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (flush_i)     w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= op_i;
            r_b    <= b_i;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_prod <= {{WIDTH{1'b0}}, a_i};
            if (w_div0) r_result <= op_i[0] ? a_i : '1;
          end
        end
        S_CALC: begin
          if (!flush_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_op[1]) begin
              r_rem  <= w_rem_nxt;
              r_prod <= {r_prod[2*WIDTH-1:WIDTH], w_quo_nxt};
            end else begin
              r_prod <= w_mul_nxt;
            end
            if (w_last) r_result <= w_calc_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (r_state == S_CALC);
  // A flush landing in the DONE cycle kills the pulse so the pipeline never
  // consumes a result belonging to a squashed instruction.
  assign done_o   = (r_state == S_DONE) & ~flush_i;
  assign result_o = r_result;
  // Qualified with rst_ni: state already reads IDLE during reset, but a
  // start_i held high must not stall the front end.
  assign stall_o  = rst_ni & (busy_o | ((r_state == S_IDLE) & w_accept));

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         stall_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_result = '0;
  logic [W-1:0] mon_exp;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (y == '0) ? '1 : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Scoreboard: every done_o pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected 0 (no operation pending)");
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {32'b0, result_o}, {32'b0, mon_exp});
        last_result = mon_exp;
      end
    end
  end

  // Issue one operation now (caller guarantees an IDLE cycle, away from edges)
  // and wait for its done_o, checking latency, busy length and stall.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] e, input int exp_lat, input string name);
    int lat;
    int busy_cnt;
    bit seen;
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(e);
    #1 check({name, "_stall_req"}, {63'b0, stall_o}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(3));
    lat = 0; busy_cnt = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy_o) busy_cnt++;
      if (done_o) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done_o in 100 cycles expected done_o", name);
      exp_q.delete();
    end else begin
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
      check({name, "_stall_done"}, {63'b0, stall_o}, 64'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'd7,        32'd6,        32'd42,       W+1};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W+1};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, W+1};
    vecs[3]  = '{2'b10, 32'd100,      32'd7,        32'd14,       W+1};
    vecs[4]  = '{2'b11, 32'd100,      32'd7,        32'd2,        W+1};
    vecs[5]  = '{2'b10, 32'h1234,     32'd0,        32'hFFFFFFFF, 1};
    vecs[6]  = '{2'b11, 32'h1234,     32'd0,        32'h1234,     1};
    vecs[7]  = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, W+1};
    vecs[8]  = '{2'b11, 32'hDEADBEEF, 32'h10,       32'hF,        W+1};
    vecs[9]  = '{2'b01, 32'h80000000, 32'd2,        32'd1,        W+1};
    vecs[10] = '{2'b10, 32'd5,        32'd10,       32'd0,        W+1};
    vecs[11] = '{2'b00, 32'h12345678, 32'd0,        32'd0,        W+1};

    // Reset state, with start_i held high to show no stall under reset.
    start = 1'b1;
    #1;
    check("rst_busy",   {63'b0, busy_o},   64'd0);
    check("rst_done",   {63'b0, done_o},   64'd0);
    check("rst_result", {32'b0, result_o}, 64'd0);
    check("rst_stall",  {63'b0, stall_o},  64'd0);
    start = 1'b0;
    #21 rst_n = 1'b1;  // t=22; first op accepted on the very next edge

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
      @(posedge clk); #1;  // the IDLE cycle after DONE: next op is back-to-back
    end

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      o = 2'(i % 4);
      x = $urandom;
      y = $urandom;
      if (i % 3 == 1) y = y >> 20;
      if (i == 6) y = '0;
      run_op(o, x, y, model(o, x, y), (o[1] && y == '0) ? 1 : W+1, $sformatf("rnd%0d", i));
      @(posedge clk); #1;
    end

    // Flush on the 10th CALC cycle.
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", {63'b0, busy_o}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy_after", {63'b0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_result_held", {32'b0, result_o}, {32'b0, last_result});

    // start and flush together in IDLE.
    @(posedge clk); #1;
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1 check("startflush_stall", {63'b0, stall_o}, 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    check("startflush_busy", {63'b0, busy_o}, 64'd0);
    repeat (3) @(negedge clk);
    check("startflush_idle", {63'b0, busy_o}, 64'd0);

    // Reset in the middle of CALC.
    @(posedge clk); #1;
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b1;
    #1;
    check("midrst_busy",   {63'b0, busy_o},   64'd0);
    check("midrst_done",   {63'b0, done_o},   64'd0);
    check("midrst_result", {32'b0, result_o}, 64'd0);
    check("midrst_stall",  {63'b0, stall_o},  64'd0);
    start = 1'b0;
    last_result = '0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(2'b00, 32'd3, 32'd5, 32'd15, W+1, "post_rst_mul");
    @(posedge clk); #1;
    repeat (4) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
